// File: rtl/xadac_rsp_reorder_if.sv
// Channel bundle for xadac_rsp_reorder: tag allocation, tagged responses, in-order release.
// Modport slave is the reorder block; modport master is the surrounding logic.
interface xadac_rsp_reorder_if #(
  parameter int unsigned NumTags = 4,
  parameter type DataT = logic
);
  localparam int unsigned TagW = $clog2(NumTags);

  logic            alloc_valid;
  logic            alloc_ready;
  logic [TagW-1:0] alloc_tag;

  DataT            rsp_data;
  logic [TagW-1:0] rsp_tag;
  logic            rsp_valid;
  logic            rsp_ready;

  DataT            mst_data;
  logic            mst_valid;
  logic            mst_ready;

  modport slave (
    input  alloc_valid, rsp_data, rsp_tag, rsp_valid, mst_ready,
    output alloc_ready, alloc_tag, rsp_ready, mst_data, mst_valid
  );

  modport master (
    output alloc_valid, rsp_data, rsp_tag, rsp_valid, mst_ready,
    input  alloc_ready, alloc_tag, rsp_ready, mst_data, mst_valid
  );
endinterface

// File: rtl/xadac_rsp_reorder.sv
// Response reorder buffer: issues in-order tags, accepts out-of-order responses, releases in tag order.
// Optional XADAC_RSP_BYPASS_EN adds a same-cycle bypass of the head slot.
module xadac_rsp_reorder #(
  parameter int unsigned NumTags = 4,
  parameter type DataT = logic
) (
  input logic               clk,
  input logic               rstn,
  xadac_rsp_reorder_if.slave bus
);
  localparam int unsigned   TagW      = $clog2(NumTags);
  localparam logic [TagW:0] FullCount = (TagW+1)'(NumTags);

  logic [TagW-1:0]    head;
  logic [TagW-1:0]    tail;
  logic [TagW:0]      count;
  logic [NumTags-1:0] alloc_q;
  logic [NumTags-1:0] filled_q;
  DataT               storage [NumTags];

  logic alloc_hs;
  logic rsp_hs;
  logic rsp_wr;
  logic mst_hs;
  logic bypass;

  always_comb begin
    bus.alloc_ready = (count != FullCount);
    bus.alloc_tag   = tail;
    bus.rsp_ready   = alloc_q[bus.rsp_tag] & ~filled_q[bus.rsp_tag];
`ifdef XADAC_RSP_BYPASS_EN
    bypass        = ~filled_q[head] & bus.rsp_valid & (bus.rsp_tag == head) & alloc_q[head];
    bus.mst_valid = filled_q[head] | bypass;
    bus.mst_data  = bypass ? bus.rsp_data : storage[head];
`else
    bypass        = 1'b0;
    bus.mst_valid = filled_q[head];
    bus.mst_data  = storage[head];
`endif
    alloc_hs = bus.alloc_valid & bus.alloc_ready;
    rsp_hs   = bus.rsp_valid & bus.rsp_ready;
    mst_hs   = bus.mst_valid & bus.mst_ready;
    // A bypassed response consumed this cycle never lands in storage.
    rsp_wr   = rsp_hs & ~(bypass & bus.mst_ready);
  end

  // Slot writes never collide on one index: release needs filled[head] (blocking a write
  // to head) and allocation of tail==head only happens when the buffer is empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      alloc_q  <= '0;
      filled_q <= '0;
      for (int unsigned i = 0; i < NumTags; i++) begin
        storage[i] <= '0;
      end
    end else begin
      if (alloc_hs) begin
        alloc_q[tail] <= 1'b1;
        tail          <= tail + TagW'(1);
      end
      if (rsp_wr) begin
        filled_q[bus.rsp_tag] <= 1'b1;
        storage[bus.rsp_tag]  <= bus.rsp_data;
      end
      if (mst_hs) begin
        alloc_q[head]  <= 1'b0;
        filled_q[head] <= 1'b0;
        head           <= head + TagW'(1);
      end
      if (alloc_hs != mst_hs) begin
        count <= alloc_hs ? count + (TagW+1)'(1) : count - (TagW+1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_xadac_rsp_reorder.sv
// Self-checking bench for xadac_rsp_reorder: directed scenarios plus random traffic
// against a queue-based model of outstanding tags (honours XADAC_RSP_BYPASS_EN).
module tb_xadac_rsp_reorder;
  localparam int unsigned NT = 4;
  typedef logic [7:0] data_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  xadac_rsp_reorder_if #(.NumTags(NT), .DataT(data_t)) bus ();
  xadac_rsp_reorder #(.NumTags(NT), .DataT(data_t)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int    vectors = 0;
  int    errors  = 0;
  int    q[$];
  bit    have [NT];
  data_t val  [NT];
  int    next_tag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    next_tag = 0;
    for (int i = 0; i < NT; i++) begin
      have[i] = 1'b0;
      val[i]  = '0;
    end
  endtask

  // One clock: drive, check outputs against the model, advance the model at the edge.
  task automatic step(input bit av, input bit rv, input int rtag, input data_t rd, input bit mr);
    bit    e_ar, e_rr, e_mv, byp, found, hv;
    data_t e_md;
    int    h;
    bus.alloc_valid = av;
    bus.rsp_valid   = rv;
    bus.rsp_tag     = 2'(rtag);
    bus.rsp_data    = rd;
    bus.mst_ready   = mr;
    #1;
    e_ar  = (q.size() != NT);
    found = 1'b0;
    foreach (q[k]) if (q[k] == rtag) found = 1'b1;
    e_rr  = found && !have[rtag];
    h     = (q.size() > 0) ? q[0] : -1;
    hv    = (h >= 0) ? have[h] : 1'b0;
    byp   = 1'b0;
`ifdef XADAC_RSP_BYPASS_EN
    byp   = (h >= 0) && !hv && rv && (rtag == h);
`endif
    e_mv  = (h >= 0) && (hv || byp);
    e_md  = byp ? rd : ((h >= 0) ? val[h] : '0);
    check("alloc_ready", 32'(bus.alloc_ready), 32'(e_ar));
    check("alloc_tag",   32'(bus.alloc_tag),   32'(next_tag));
    check("rsp_ready",   32'(bus.rsp_ready),   32'(e_rr));
    check("mst_valid",   32'(bus.mst_valid),   32'(e_mv));
    if (e_mv) check("mst_data", 32'(bus.mst_data), 32'(e_md));
    @(posedge clk);
    if (e_mv && mr) begin
      have[h] = 1'b0;
      void'(q.pop_front());
    end
    if (rv && e_rr && !(byp && mr)) begin
      have[rtag] = 1'b1;
      val[rtag]  = rd;
    end
    if (av && e_ar) begin
      q.push_back(next_tag);
      next_tag = (next_tag + 1) % NT;
    end
    #1;
  endtask

  task automatic pulse_reset();
    bus.alloc_valid = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_tag     = '0;
    bus.rsp_data    = '0;
    bus.mst_ready   = 1'b1;
    rstn = 1'b0;
    #1;
    model_clear();
    check("rst_mst_valid",   32'(bus.mst_valid),   32'd0);
    check("rst_mst_data",    32'(bus.mst_data),    32'd0);
    check("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    check("rst_alloc_tag",   32'(bus.alloc_tag),   32'd0);
    check("rst_rsp_ready",   32'(bus.rsp_ready),   32'd0);
    @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rt;
    rstn = 1'b0;
    model_clear();
    pulse_reset();

    // Idle: no tag accepts a response.
    for (int t = 0; t < NT; t++) step(1'b0, 1'b1, t, 8'h11, 1'b1);

    // Four back-to-back allocations, fifth is held.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 8'h00, 1'b0);

    // Out-of-order fill, in-order release.
    step(1'b0, 1'b1, 2, 8'h0C, 1'b1);
    step(1'b0, 1'b1, 0, 8'h0A, 1'b1);
    step(1'b0, 1'b1, 3, 8'h0D, 1'b1);
    step(1'b0, 1'b1, 1, 8'h0B, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 8'h00, 1'b1);

    // Backpressure on a filled head, duplicate response stalls.
    step(1'b1, 1'b0, 0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 0, 8'h05, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 0, 8'h77, 1'b0);
    step(1'b0, 1'b0, 0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 0, 8'h00, 1'b1);

    // Wrap-around with allocation and release in the same cycle.
    step(1'b1, 1'b0, 0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      rt = (q.size() > 0) ? q[q.size()-1] : 0;
      step(1'b1, 1'b1, rt, 8'($urandom), 1'b1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 0, 8'h00, 1'b1);

    // Random traffic, including protocol-violating responses that must stall.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, NT-1)), 8'($urandom),
           ($urandom_range(0, 9) < 7));
    end

    // Reset with three outstanding tags, two of them filled.
    pulse_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 0, 8'hA1, 1'b0);
    step(1'b0, 1'b1, 1, 8'hA2, 1'b0);
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 0, 8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/xadac_rsp_reorder.md
Name: xadac_rsp_reorder

Overview:
- Return-path block for the xadac accelerator interface.
- Hands an in-order tag to each issued request on the allocation port.
- Accepts tagged responses from execution units in any order.
- Releases responses to the upstream consumer strictly in allocation order over a valid/ready master port.
- Sits between the execution units' response outputs and the core-side response channel. It is the counterpart of the request-side register slices.

Parameters:
- NumTags, 4, number of outstanding tags / storage slots; power of two, >= 2.
- DataT, logic, response payload type.
- TagW, $clog2(NumTags), tag width; derived, not overridden.

Ports:
- clk  input  1  clock, all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- alloc_valid  input  1  requester wants a tag.
- alloc_ready  output  1  a free slot exists.
- alloc_tag  output  TagW  tag granted when alloc_valid && alloc_ready.
- rsp_data  input  DataT  response payload.
- rsp_tag  input  TagW  tag of the response.
- rsp_valid  input  1  response present.
- rsp_ready  output  1  response accepted.
- mst_data  output  DataT  in-order response payload.
- mst_valid  output  1  in-order response present.
- mst_ready  input  1  consumer accepts.

Behaviour:
- State:
  - tail (next tag to allocate), TagW bits.
  - head (oldest outstanding tag), TagW bits.
  - count, TagW+1 bits.
  - per slot: alloc bit, filled bit, DataT storage.
- Reset (async, rstn low): head=0, tail=0, count=0, all alloc/filled bits 0, storage cleared to '0.
- Output values while and right after reset: alloc_ready=1, alloc_tag=0, rsp_ready=0, mst_valid=0, mst_data='0.
- Reset asserted mid-operation drops all outstanding tags and buffered data; nothing is emitted afterwards for them.
- Allocation:
  - alloc_ready = (count != NumTags); alloc_tag = tail.
  - On the handshake: alloc[tail]<=1, tail<=tail+1 (wraps modulo NumTags), count increments.
  - alloc_ready does not depend on mst_ready. A same-cycle release does not free a slot for a same-cycle allocation when full.
- Response:
  - rsp_ready = alloc[rsp_tag] && !filled[rsp_tag].
  - On the handshake: storage[rsp_tag]<=rsp_data, filled[rsp_tag]<=1.
  - A response to an unallocated or already-filled tag is stalled indefinitely (rsp_ready=0). It is a protocol violation.
- Release:
  - mst_valid = filled[head]; mst_data = storage[head].
  - On the mst handshake: alloc[head]<=0, filled[head]<=0, head<=head+1 (wraps), count decrements.
  - mst_data is held stable while mst_valid && !mst_ready.
- Latency: a response written to the head slot appears on mst_valid the next cycle (1 cycle). Responses to younger tags wait until all older tags have been released.
- Simultaneous events:
  - Allocate and release in one cycle: count unchanged, both pointers advance.
  - A response writes tag X while release retires head Y != X: both take effect.
  - X == head cannot be written while filled[head]=1, because rsp_ready is 0.
- Full: count==NumTags means alloc_ready=0. Empty: count==0 means mst_valid=0 and rsp_ready=0 for every tag.

Optional Feature:
- Macro: XADAC_RSP_BYPASS_EN.
- When defined, a same-cycle bypass of the head slot is added. The condition is !filled[head] && rsp_valid && rsp_tag==head && alloc[head].
  - mst_valid=1 and mst_data=rsp_data combinationally, giving 0-cycle latency.
  - If mst_ready=1 the slot is not written and head retires the same cycle.
  - If mst_ready=0 the response is written to the slot as normal and presented from storage next cycle.
- When undefined: no combinational path from rsp_* to mst_*; latency is always >= 1 cycle.

Test Plan:
- Reset then idle: alloc_ready=1, alloc_tag=0, mst_valid=0, rsp_ready=0 for tags 0..3.
- Allocate tags 0,1,2,3 back-to-back with NumTags=4 -> alloc_tag 0,1,2,3 on successive cycles; alloc_ready=0 after the 4th; a 5th request is held.
- Out-of-order fill: after 4 allocs, return tag 2 (0xC), tag 0 (0xA), tag 3 (0xD), tag 1 (0xB) with mst_ready=1 -> mst emits 0xA, then 0xB, 0xC, 0xD in order; 0xA is emitted 1 cycle after tag 0 is written (or the same cycle with XADAC_RSP_BYPASS_EN).
- Backpressure: head filled with 0x5 and mst_ready=0 for 5 cycles -> mst_valid=1 and mst_data=0x5 stable throughout; a duplicate response for the head tag sees rsp_ready=0.
- Wrap-around: 10 alloc/response/release rounds with allocation and release in the same cycle -> tags cycle 0,1,2,3,0,1,...; count never exceeds 4; data order preserved.
- Reset mid-operation: with 3 outstanding tags and 2 filled, pulse rstn low -> mst_valid=0 immediately; after release alloc_tag=0; the old data is never emitted.
